// File: rtl/mgmt_qspi_host.sv
// -----------------------------------------------------------------------------
// mgmt_qspi_host
//
// Quad-SPI host that issues one management transaction per command to the
// management bridge's QSPI device port. A frame carries an opcode byte
// (0x02 write, 0x0B read), a 24-bit address and a 16-bit data word. All fields
// are sent as MSB-first nibbles on four lines. A read inserts DUMMY_CYCLES
// turnaround SCK periods, with the DQ bus released, before the device returns
// the data. The SPI mode is 0: SCK idles low, the host changes DQ only while
// SCK is low, and it samples on the rising edge.
//
// Ports
//   clk, rst_n      core clock; asynchronous active-low reset
//   cmd_valid/ready request handshake; accepted when both are high
//   cmd_write       1 = write, 0 = read
//   cmd_addr        24-bit bus address
//   cmd_wdata       16-bit write data
//   rsp_valid       one-cycle completion pulse (same cycle cs_n rises)
//   rsp_rdata       read data (0x0000 for writes), held until next rsp_valid
//   qspi_sck        serial clock, idles low
//   qspi_cs_n       chip select, active low
//   qspi_dq_out     DQ drive value
//   qspi_dq_oe      DQ output enable
//   qspi_dq_in      DQ sampled value, already synchronised to clk
// -----------------------------------------------------------------------------
module mgmt_qspi_host #(
    parameter int unsigned CLK_DIV      = 4,  // clk cycles per SCK half-period (1..255)
    parameter int unsigned DUMMY_CYCLES = 8,  // turnaround SCK periods on reads
    parameter int unsigned CS_GAP       = 8   // minimum clk cycles cs_n stays high
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [23:0] cmd_addr,
    input  logic [15:0] cmd_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        qspi_sck,
    output logic        qspi_cs_n,
    output logic [3:0]  qspi_dq_out,
    output logic        qspi_dq_oe,
    input  logic [3:0]  qspi_dq_in
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_SHIFT_OUT,
        ST_TURN,
        ST_SHIFT_IN,
        ST_HOLD,
        ST_DESELECT,
        ST_GAP
    } state_t;

    localparam logic [7:0]  OP_WRITE  = 8'h02;
    localparam logic [7:0]  OP_READ   = 8'h0B;
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam bit          HAS_GAP   = (CS_GAP > 1);
    localparam logic [15:0] GAP_LAST  = HAS_GAP ? 16'(CS_GAP - 2) : 16'd0;
    localparam bit          HAS_TURN  = (DUMMY_CYCLES > 0);
    localparam logic [7:0]  TURN_LAST = HAS_TURN ? 8'(DUMMY_CYCLES - 1) : 8'd0;
    localparam logic [7:0]  WR_LAST   = 8'd11;  // opcode + address + data nibbles, minus one
    localparam logic [7:0]  RD_LAST   = 8'd7;   // opcode + address nibbles, minus one
    localparam logic [7:0]  IN_LAST   = 8'd3;   // four read-data nibbles, minus one

    state_t      state_q,    state_d;
    logic [15:0] cnt_q,      cnt_d;       // half-period / gap counter
    logic [7:0]  nib_q,      nib_d;       // SCK period index within the current state
    logic        is_write_q, is_write_d;
    logic [47:0] frame_q,    frame_d;     // outgoing nibbles still to be driven, MSB first
    logic [15:0] rdata_sh_q, rdata_sh_d;
    logic        sck_q,      sck_d;
    logic        cs_n_q,     cs_n_d;
    logic        oe_q,       oe_d;
    logic [3:0]  dq_q,       dq_d;
    logic        ready_q,    ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;

    logic        phase_end;
    logic [7:0]  out_last;
    logic [7:0]  opcode;

    assign phase_end = (cnt_q == DIV_LAST);
    assign out_last  = is_write_q ? WR_LAST : RD_LAST;
    assign opcode    = cmd_write ? OP_WRITE : OP_READ;

    // Every SCK period inside SHIFT_OUT / TURN / SHIFT_IN is a high half
    // followed by a low half. The rise that opens a period is issued when
    // the previous low half (or SELECT) ends, so a state change always lands
    // on a low-half boundary and no SCK edge is lost or doubled.
    always_comb begin
        // NOTE: every signal gets its hold value first so no path through the
        // case statement can leave one unassigned and infer a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        nib_d       = nib_q;
        is_write_d  = is_write_q;
        frame_d     = frame_q;
        rdata_sh_d  = rdata_sh_q;
        sck_d       = sck_q;
        cs_n_d      = cs_n_q;
        oe_d        = oe_q;
        dq_d        = dq_q;
        ready_d     = ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                if (cmd_valid && ready_q) begin
                    state_d    = ST_SELECT;
                    ready_d    = 1'b0;
                    cs_n_d     = 1'b0;
                    oe_d       = 1'b1;
                    is_write_d = cmd_write;
                    dq_d       = opcode[7:4];
                    frame_d    = {opcode[3:0], cmd_addr, cmd_wdata, 4'h0};
                    rdata_sh_d = 16'h0000;
                    cnt_d      = 16'd0;
                    nib_d      = 8'd0;
                end
            end

            ST_SELECT: begin
                if (phase_end) begin
                    cnt_d   = 16'd0;
                    sck_d   = 1'b1;
                    state_d = ST_SHIFT_OUT;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_SHIFT_OUT: begin
                if (!phase_end) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = 16'd0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                        if (nib_q == out_last) begin
                            // Last nibble sampled: release the bus for the
                            // read turnaround or the write's closing hold.
                            oe_d = 1'b0;
                            dq_d = 4'h0;
                        end else begin
                            dq_d    = frame_q[47:44];
                            frame_d = {frame_q[43:0], 4'h0};
                        end
                    end else if (nib_q == out_last) begin
                        nib_d = 8'd0;
                        if (is_write_q) begin
                            state_d = ST_HOLD;
                        end else if (HAS_TURN) begin
                            state_d = ST_TURN;
                            sck_d   = 1'b1;
                        end else begin
                            state_d    = ST_SHIFT_IN;
                            sck_d      = 1'b1;
                            rdata_sh_d = {rdata_sh_q[11:0], qspi_dq_in};
                        end
                    end else begin
                        nib_d = nib_q + 8'd1;
                        sck_d = 1'b1;
                    end
                end
            end

            ST_TURN: begin
                if (!phase_end) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = 16'd0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                    end else if (nib_q == TURN_LAST) begin
                        // This rise opens the first data period: sample now.
                        nib_d      = 8'd0;
                        state_d    = ST_SHIFT_IN;
                        sck_d      = 1'b1;
                        rdata_sh_d = {rdata_sh_q[11:0], qspi_dq_in};
                    end else begin
                        nib_d = nib_q + 8'd1;
                        sck_d = 1'b1;
                    end
                end
            end

            ST_SHIFT_IN: begin
                if (!phase_end) begin
                    cnt_d = cnt_q + 16'd1;
                end else begin
                    cnt_d = 16'd0;
                    if (sck_q) begin
                        sck_d = 1'b0;
                    end else if (nib_q == IN_LAST) begin
                        nib_d   = 8'd0;
                        state_d = ST_HOLD;
                    end else begin
                        nib_d      = nib_q + 8'd1;
                        sck_d      = 1'b1;
                        rdata_sh_d = {rdata_sh_q[11:0], qspi_dq_in};
                    end
                end
            end

            ST_HOLD: begin
                if (phase_end) begin
                    cnt_d       = 16'd0;
                    state_d     = ST_DESELECT;
                    cs_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = is_write_q ? 16'h0000 : rdata_sh_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            ST_DESELECT: begin
                cnt_d = 16'd0;
                if (HAS_GAP) begin
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end
            end

            ST_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    cnt_d   = 16'd0;
                    state_d = ST_IDLE;
                    ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
                cs_n_d  = 1'b1;
                sck_d   = 1'b0;
                oe_d    = 1'b0;
            end
        endcase
    end

    // All pin-side outputs come straight from flops so SCK, CS_N and DQ are
    // glitch-free; the asynchronous reset parks the bus within the cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 16'd0;
            nib_q       <= 8'd0;
            is_write_q  <= 1'b0;
            frame_q     <= 48'h0;
            rdata_sh_q  <= 16'h0000;
            sck_q       <= 1'b0;
            cs_n_q      <= 1'b1;
            oe_q        <= 1'b0;
            dq_q        <= 4'h0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the values
            // from before this edge regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            nib_q       <= nib_d;
            is_write_q  <= is_write_d;
            frame_q     <= frame_d;
            rdata_sh_q  <= rdata_sh_d;
            sck_q       <= sck_d;
            cs_n_q      <= cs_n_d;
            oe_q        <= oe_d;
            dq_q        <= dq_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign qspi_sck    = sck_q;
    assign qspi_cs_n   = cs_n_q;
    assign qspi_dq_out = dq_q;
    assign qspi_dq_oe  = oe_q;

endmodule

// File: tb/tb_mgmt_qspi_host.sv
// -----------------------------------------------------------------------------
// tb_mgmt_qspi_host
//
// Drives two host instances (CLK_DIV=2 and CLK_DIV=1) through directed and
// random transactions. A pin monitor records every SCK rise, the cs_n low
// time and the responses, and plays the device for reads. Expected frames,
// durations and read data come from the frame rules, computed here.
// -----------------------------------------------------------------------------
module tb_mgmt_qspi_host;

    localparam int DIV_A = 2;
    localparam int DIV_B = 1;
    localparam int DUMMY = 8;
    localparam int GAP   = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        sel = 1'b0;  // 0 selects the CLK_DIV=2 instance, 1 the CLK_DIV=1 one
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [23:0] cmd_addr = '0;
    logic [15:0] cmd_wdata = '0;
    logic [3:0]  dq_in = '0;

    logic        ready_a, rsp_valid_a, sck_a, cs_n_a, oe_a;
    logic [15:0] rdata_a;
    logic [3:0]  dq_a;
    logic        ready_b, rsp_valid_b, sck_b, cs_n_b, oe_b;
    logic [15:0] rdata_b;
    logic [3:0]  dq_b;

    mgmt_qspi_host #(.CLK_DIV(DIV_A), .DUMMY_CYCLES(DUMMY), .CS_GAP(GAP)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & ~sel), .cmd_ready(ready_a), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_a), .rsp_rdata(rdata_a),
        .qspi_sck(sck_a), .qspi_cs_n(cs_n_a), .qspi_dq_out(dq_a), .qspi_dq_oe(oe_a),
        .qspi_dq_in(dq_in)
    );

    mgmt_qspi_host #(.CLK_DIV(DIV_B), .DUMMY_CYCLES(DUMMY), .CS_GAP(GAP)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid & sel), .cmd_ready(ready_b), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid_b), .rsp_rdata(rdata_b),
        .qspi_sck(sck_b), .qspi_cs_n(cs_n_b), .qspi_dq_out(dq_b), .qspi_dq_oe(oe_b),
        .qspi_dq_in(dq_in)
    );

    wire        o_ready = sel ? ready_b     : ready_a;
    wire        o_rsp   = sel ? rsp_valid_b : rsp_valid_a;
    wire [15:0] o_rdata = sel ? rdata_b     : rdata_a;
    wire        o_sck   = sel ? sck_b       : sck_a;
    wire        o_cs_n  = sel ? cs_n_b      : cs_n_a;
    wire        o_oe    = sel ? oe_b        : oe_a;
    wire [3:0]  o_dq    = sel ? dq_b        : dq_a;

    int tests = 0;
    int fails = 0;

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- pin monitor and read-data device model ----------------
    int          cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] rd_model = '0;
    logic [3:0]  rise_dq[$];
    logic        rise_oe[$];
    int          rise_cyc[$];
    int          csrise_cyc[$];
    int          csfall_cyc[$];
    int          low_cnt = 0, rsp_cnt = 0, viol = 0, frame_rises = 0;
    int          rsp_cyc = -1, ready_cyc = -1;
    logic [15:0] rsp_seen = '0;
    logic        rsp_cs_n = 1'b0;
    logic        prev_sck = 1'b0, prev_cs = 1'b1, prev_ready = 1'b1;
    logic [3:0]  prev_dq = '0;

    always @(negedge clk) begin
        if (!o_cs_n) low_cnt++;
        if (o_cs_n && !prev_cs) csrise_cyc.push_back(cyc);
        if (!o_cs_n && prev_cs) begin
            csfall_cyc.push_back(cyc);
            frame_rises = 0;
        end
        if (o_sck && !prev_sck) begin
            rise_dq.push_back(o_dq);
            rise_oe.push_back(o_oe);
            rise_cyc.push_back(cyc);
            frame_rises++;
            if (o_dq !== prev_dq) viol++;
        end
        if (o_sck && prev_sck && (o_dq !== prev_dq)) viol++;
        if (o_cs_n && o_sck) viol++;
        if (o_rsp) begin
            rsp_cnt++;
            rsp_seen = o_rdata;
            rsp_cyc  = cyc;
            rsp_cs_n = o_cs_n;
        end
        if (o_ready && !prev_ready) ready_cyc = cyc;
        // Rises 17..20 of a read frame carry the data, after 8 command/address
        // rises and DUMMY turnaround rises; anything else sees noise.
        if (frame_rises >= 8 + DUMMY && frame_rises < 12 + DUMMY)
            dq_in = rd_model[4*(11 + DUMMY - frame_rises) +: 4];
        else
            dq_in = 4'($urandom);
        prev_sck   = o_sck;
        prev_cs    = o_cs_n;
        prev_ready = o_ready;
        prev_dq    = o_dq;
    end

    task automatic mon_clear();
        rise_dq.delete();
        rise_oe.delete();
        rise_cyc.delete();
        csrise_cyc.delete();
        csfall_cyc.delete();
        low_cnt   = 0;
        rsp_cnt   = 0;
        viol      = 0;
        rsp_cyc   = -1;
        ready_cyc = -1;
    endtask

    // Present a command and return one cycle after it has been accepted.
    task automatic issue(input logic wr, input logic [23:0] addr, input logic [15:0] wdata);
        int k;
        @(posedge clk); #1;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        k = 0;
        while (!o_ready && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        cmd_write = 1'($urandom);
        cmd_addr  = 24'($urandom);
        cmd_wdata = 16'($urandom);
    endtask

    task automatic wait_rsp(input int n);
        int k;
        k = 0;
        while (rsp_cnt < n && k < 3000) begin
            @(posedge clk);
            k++;
        end
    endtask

    function automatic logic [47:0] frame_word(input logic wr, input logic [23:0] addr,
                                               input logic [15:0] wdata);
        return {(wr ? 8'h02 : 8'h0B), addr, wdata};
    endfunction

    // One complete transaction on the selected instance, checked against the
    // frame rules: nibbles on each rise, oe pattern, SCK period, cs_n low
    // time, response pulse/data and the idle gap before cmd_ready returns.
    task automatic run_txn(input logic wr, input logic [23:0] addr, input logic [15:0] wdata,
                           input logic [15:0] rdat, input string tag);
        int          div, n_out, n_rise, exp_low, mism, last_rise;
        logic [47:0] word;
        div     = sel ? DIV_B : DIV_A;
        n_out   = wr ? 12 : 8;
        n_rise  = wr ? 12 : 12 + DUMMY;
        exp_low = wr ? 26 * div : div * (2 + 2 * (12 + DUMMY));
        word    = frame_word(wr, addr, wdata);
        mon_clear();
        rd_model = rdat;
        issue(wr, addr, wdata);
        wait_rsp(1);
        repeat (GAP + 3) @(posedge clk);

        check({tag, "_rises"}, rise_dq.size(), n_rise);
        mism = 0;
        for (int i = 0; i < n_rise && i < rise_dq.size(); i++) begin
            if (i < n_out && rise_dq[i] !== word[47 - 4*i -: 4]) mism++;
            if (rise_oe[i] !== (i < n_out)) mism++;
        end
        check({tag, "_nibble_mism"}, mism, 0);
        if (rise_cyc.size() >= 2)
            check({tag, "_sck_period"}, rise_cyc[1] - rise_cyc[0], 2 * div);
        check({tag, "_cs_low"}, low_cnt, exp_low);
        check({tag, "_rsp_cnt"}, rsp_cnt, 1);
        check({tag, "_rsp_data"}, rsp_seen, wr ? 16'h0000 : rdat);
        check({tag, "_rsp_cs_n"}, rsp_cs_n, 1'b1);
        last_rise = (csrise_cyc.size() > 0) ? csrise_cyc[csrise_cyc.size() - 1] : -1000;
        check({tag, "_rsp_at_cs_rise"}, rsp_cyc, last_rise);
        check({tag, "_ready_gap"}, ready_cyc - last_rise, GAP);
        check({tag, "_mode0_viol"}, viol, 0);
        check({tag, "_rdata_hold"}, o_rdata, wr ? 16'h0000 : rdat);
    endtask

    initial begin
        int          k, mism, gap;
        logic [47:0] w1, w2;

        // ---------------- reset defaults ----------------
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs_n",  o_cs_n,  1'b1);
        check("rst_sck",   o_sck,   1'b0);
        check("rst_oe",    o_oe,    1'b0);
        check("rst_dq",    o_dq,    4'h0);
        check("rst_ready", o_ready, 1'b1);
        check("rst_rsp",   o_rsp,   1'b0);
        check("rst_rdata", o_rdata, 16'h0000);
        @(negedge clk) rst_n = 1'b1;
        mon_clear();
        repeat (5) @(posedge clk);
        #1;
        check("post_rst_cs_n",  o_cs_n,  1'b1);
        check("post_rst_sck",   o_sck,   1'b0);
        check("post_rst_oe",    o_oe,    1'b0);
        check("post_rst_ready", o_ready, 1'b1);
        check("post_rst_rsp_cnt", rsp_cnt, 0);

        // ---------------- directed frames, CLK_DIV=2 ----------------
        sel = 1'b0;
        run_txn(1'b1, 24'h001000, 16'hA5C3, 16'h0000, "wr_div2");
        run_txn(1'b0, 24'h00A000, 16'h0000, 16'h1234, "rd_div2");

        // ---------------- back-to-back writes, cmd_valid held ----------------
        w1 = frame_word(1'b1, 24'h123456, 16'hBEEF);
        w2 = frame_word(1'b1, 24'hABCDEF, 16'h0F1E);
        mon_clear();
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 24'h123456; cmd_wdata = 16'hBEEF;
        k = 0;
        while (!o_ready && k < 200) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        cmd_addr = 24'hABCDEF; cmd_wdata = 16'h0F1E;  // held valid; must wait for idle
        k = 0;
        while (!o_ready && k < 500) begin @(posedge clk); #1; k++; end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wait_rsp(2);
        repeat (GAP + 3) @(posedge clk);
        check("b2b_rsp_cnt", rsp_cnt, 2);
        check("b2b_rises", rise_dq.size(), 24);
        mism = 0;
        for (int i = 0; i < 24 && i < rise_dq.size(); i++) begin
            if (i < 12 && rise_dq[i] !== w1[47 - 4*i -: 4]) mism++;
            if (i >= 12 && rise_dq[i] !== w2[47 - 4*(i-12) -: 4]) mism++;
        end
        check("b2b_nibble_mism", mism, 0);
        check("b2b_cs_falls", csfall_cyc.size(), 2);
        gap = (csfall_cyc.size() >= 2 && csrise_cyc.size() >= 1) ? csfall_cyc[1] - csrise_cyc[0] : 0;
        check("b2b_gap_ge", (gap >= GAP + 1), 1'b1);
        check("b2b_cs_low", low_cnt, 2 * 26 * DIV_A);
        check("b2b_mode0_viol", viol, 0);

        // ---------------- reset in the middle of a read ----------------
        mon_clear();
        rd_model = 16'hCAFE;
        issue(1'b0, 24'h00ABCD, 16'h0000);
        k = 0;
        while (frame_rises < 5 && k < 500) begin @(negedge clk); #1; k++; end
        rst_n = 1'b0;
        #1;
        check("midrst_cs_n", o_cs_n, 1'b1);
        check("midrst_sck",  o_sck,  1'b0);
        check("midrst_oe",   o_oe,   1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (GAP + 30) @(posedge clk);
        check("midrst_no_rsp", rsp_cnt, 0);
        check("midrst_ready", o_ready, 1'b1);
        run_txn(1'b1, 24'h5A5A5A, 16'h3C3C, 16'h0000, "wr_after_rst");

        // ---------------- CLK_DIV=1 ----------------
        sel = 1'b1;
        run_txn(1'b1, 24'hFFFFFF, 16'hFFFF, 16'h0000, "wr_div1_ff");

        // ---------------- random frames on both instances ----------------
        for (int t = 0; t < 8; t++) begin
            sel = 1'(t % 2);
            run_txn(1'($urandom), 24'($urandom), 16'($urandom), 16'($urandom),
                    $sformatf("rand%0d", t));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
